// File: rtl/score_pkg.sv
// Shared types and constants for the two-player score keeper.
package score_pkg;

    localparam int SCORE_W  = 2;
    localparam int NUM_BTNS = 3;

    // Bit positions of each button in the packed button vectors.
    localparam int BTN_P1  = 0;
    localparam int BTN_P2  = 1;
    localparam int BTN_CLR = 2;

    typedef enum logic [1:0] {
        PLAY   = 2'd0,
        P1_WIN = 2'd1,
        P2_WIN = 2'd2
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, and a
// one-cycle pulse on each accepted press (rising stable level only).
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1, sync2;
    logic             stable, stable_q;
    logic [CNT_W-1:0] cnt;

    // Bring the raw asynchronous level into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has disagreed with the stable level
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else if (sync2 == stable) begin
            cnt    <= '0;
        end else if (cnt == CNT_LAST) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt    <= cnt + CNT_W'(1);
        end
    end

    // Delayed copy of the stable level for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stable_q <= 1'b0;
        else     stable_q <= stable;
    end

    assign pulse = stable & ~stable_q;

endmodule

// File: rtl/score_ctrl.sv
// Two-player point keeper: debounced buttons feed a small game FSM that
// owns both scores and decodes the winner from registered state.
module score_ctrl
    import score_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WIN_SCORE       = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_p1,
    input  logic               btn_p2,
    input  logic               btn_clear,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [1:0]         winner,
    output logic               game_over
);

    localparam logic [SCORE_W-1:0] WIN_VAL = SCORE_W'(WIN_SCORE);

    logic [NUM_BTNS-1:0] raw_btn;
    logic [NUM_BTNS-1:0] pulse;

    assign raw_btn = {btn_clear, btn_p2, btn_p1};

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk  (clk),
            .rst  (rst),
            .raw  (raw_btn[i]),
            .pulse(pulse[i])
        );
    end

    state_t             state, state_nxt;
    logic [SCORE_W-1:0] score1_nxt, score2_nxt;

    // Game state and score registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= PLAY;
            score1 <= '0;
            score2 <= '0;
        end else begin
            state  <= state_nxt;
            score1 <= score1_nxt;
            score2 <= score2_nxt;
        end
    end

    // Next state: clear wins over points; simultaneous points are replayed;
    // win states freeze the scores. Scores stay below WIN_SCORE in PLAY,
    // so an increment can never overshoot or wrap.
    always_comb begin
        state_nxt  = state;
        score1_nxt = score1;
        score2_nxt = score2;
        if (pulse[BTN_CLR]) begin
            state_nxt  = PLAY;
            score1_nxt = '0;
            score2_nxt = '0;
        end else begin
            case (state)
                PLAY: begin
                    if (pulse[BTN_P1] && !pulse[BTN_P2]) begin
                        score1_nxt = score1 + SCORE_W'(1);
                        if (score1_nxt == WIN_VAL) state_nxt = P1_WIN;
                    end else if (pulse[BTN_P2] && !pulse[BTN_P1]) begin
                        score2_nxt = score2 + SCORE_W'(1);
                        if (score2_nxt == WIN_VAL) state_nxt = P2_WIN;
                    end
                end
                P1_WIN, P2_WIN: ;
                default: state_nxt = PLAY;
            endcase
        end
    end

    // Outputs decoded from the registered state only.
    always_comb begin
        winner    = WIN_NONE;
        game_over = 1'b0;
        case (state)
            P1_WIN: begin winner = WIN_P1; game_over = 1'b1; end
            P2_WIN: begin winner = WIN_P2; game_over = 1'b1; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_score_ctrl.sv
// Bench for score_ctrl: directed scenarios plus randomized button traffic,
// all checked against a sample-history reference model of the game.
module tb_score_ctrl;

    localparam int D  = 4;
    localparam int WS = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_p1, btn_p2, btn_clear;
    logic [1:0] score1, score2, winner;
    logic       game_over;

    int checks   = 0;
    int failures = 0;

    score_ctrl #(.DEBOUNCE_CYCLES(D), .WIN_SCORE(WS)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_p1   (btn_p1),
        .btn_p2   (btn_p2),
        .btn_clear(btn_clear),
        .score1   (score1),
        .score2   (score2),
        .winner   (winner),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    logic [6:0] got;
    assign got = {score1, score2, winner, game_over};

    // Reference model: a button level is accepted once D consecutive
    // synchronized samples (raw sampled two edges earlier) all disagree
    // with the accepted level; a press takes effect on the following edge.
    bit hist[3][$];
    bit stb[3];
    bit pend[3];
    int m_s1, m_s2, m_st;  // m_st: 0 playing, 1 player-1 won, 2 player-2 won

    function void model_reset();
        for (int b = 0; b < 3; b++) begin
            hist[b].delete();
            for (int k = 0; k < D + 2; k++) hist[b].push_back(1'b0);
            stb[b]  = 1'b0;
            pend[b] = 1'b0;
        end
        m_s1 = 0; m_s2 = 0; m_st = 0;
    endfunction

    function void model_edge();
        bit raw[3];
        bit flip;
        raw[0] = btn_p1; raw[1] = btn_p2; raw[2] = btn_clear;
        if (rst) begin
            model_reset();
            return;
        end
        if (pend[2]) begin
            m_s1 = 0; m_s2 = 0; m_st = 0;
        end else if (m_st == 0 && pend[0] && !pend[1]) begin
            m_s1++;
            if (m_s1 == WS) m_st = 1;
        end else if (m_st == 0 && pend[1] && !pend[0]) begin
            m_s2++;
            if (m_s2 == WS) m_st = 2;
        end
        for (int b = 0; b < 3; b++) begin
            hist[b].push_back(raw[b]);
            if (hist[b].size() > D + 4) void'(hist[b].pop_front());
            flip = 1'b1;
            for (int k = 2; k <= D + 1; k++)
                if (hist[b][hist[b].size() - 1 - k] == stb[b]) flip = 1'b0;
            pend[b] = flip && !stb[b];
            if (flip) stb[b] = !stb[b];
        end
    endfunction

    function logic [6:0] model_vec();
        logic [1:0] w;
        w = (m_st == 1) ? 2'b01 : (m_st == 2) ? 2'b10 : 2'b00;
        return {m_s1[1:0], m_s2[1:0], w, (m_st != 0)};
    endfunction

    // One clock: model follows the posedge, bench resumes at the negedge.
    task tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task press(input bit p1, input bit p2, input bit clr);
        btn_p1 = p1; btn_p2 = p2; btn_clear = clr;
        repeat (D + 4) tick();
        btn_p1 = 0; btn_p2 = 0; btn_clear = 0;
        repeat (D + 4) tick();
    endtask

    task do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task test_reset();
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL reset_initial: got %b expected %b", got, 7'b0);
        end
        rst = 1'b0;
        model_reset();
        tick();
        press(1, 0, 0); press(1, 0, 0); press(0, 1, 0);
        checks++;
        if (got !== 7'b10_01_00_0 || got !== model_vec()) begin
            failures++;
            $display("FAIL reset_setup_2_1: got %b expected %b", got, 7'b10_01_00_0);
        end
        // Asynchronous reset between edges.
        #2 rst = 1'b1;
        #1;
        checks++;
        if (got !== 7'b0) begin
            failures++;
            $display("FAIL reset_async: got %b expected %b", got, 7'b0);
        end
        model_reset();
        #1 rst = 1'b0;
        tick();
        // Reset mid-debounce must discard the partial count.
        btn_p1 = 1'b1;
        repeat (3) tick();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        repeat (D + 1) tick();
        checks++;
        if (got !== 7'b0 || got !== model_vec()) begin
            failures++;
            $display("FAIL reset_mid_debounce: got %b expected %b", got, 7'b0);
        end
        repeat (3) tick();
        btn_p1 = 1'b0;
        repeat (D + 4) tick();
        checks++;
        if (got !== 7'b01_00_00_0 || got !== model_vec()) begin
            failures++;
            $display("FAIL reset_resume_press: got %b expected %b", got, 7'b01_00_00_0);
        end
    endtask

    task test_single_press();
        do_reset();
        btn_p1 = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            if (e == 6) begin
                checks++;
                if (score1 !== 2'd0) begin
                    failures++;
                    $display("FAIL press_latency_early: score1=%0d expected 0", score1);
                end
            end
            if (e == 7 || e == 12) begin
                checks++;
                if (score1 !== 2'd1 || got !== model_vec()) begin
                    failures++;
                    $display("FAIL press_latency_e%0d: score1=%0d expected 1", e, score1);
                end
            end
        end
        btn_p1 = 1'b0;
        repeat (D + 4) tick();
    endtask

    task test_bounce();
        bit pat[8];
        pat = '{1, 1, 0, 0, 1, 1, 0, 0};
        for (int i = 0; i < 8; i++) begin
            btn_p1 = pat[i];
            tick();
            checks++;
            if (score1 !== 2'd1 || got !== model_vec()) begin
                failures++;
                $display("FAIL bounce_reject_%0d: score1=%0d expected 1", i, score1);
            end
        end
        btn_p1 = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (e == 6 || e == 7 || e == 10) begin
                checks++;
                if (score1 !== ((e >= 7) ? 2'd2 : 2'd1) || got !== model_vec()) begin
                    failures++;
                    $display("FAIL bounce_accept_e%0d: score1=%0d expected %0d",
                             e, score1, (e >= 7) ? 2 : 1);
                end
            end
        end
        btn_p1 = 1'b0;
        repeat (D + 4) tick();
    endtask

    task test_win();
        do_reset();
        press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
        checks++;
        if (got !== 7'b11_00_01_1 || got !== model_vec()) begin
            failures++;
            $display("FAIL win_p1: got %b expected %b", got, 7'b11_00_01_1);
        end
        press(0, 1, 0);
        checks++;
        if (got !== 7'b11_00_01_1 || got !== model_vec()) begin
            failures++;
            $display("FAIL win_frozen: got %b expected %b", got, 7'b11_00_01_1);
        end
    endtask

    task test_simultaneous();
        do_reset();
        press(1, 1, 0);
        checks++;
        if (got !== 7'b0 || got !== model_vec()) begin
            failures++;
            $display("FAIL simultaneous_replay: got %b expected %b", got, 7'b0);
        end
        press(1, 0, 0);
        checks++;
        if (got !== 7'b01_00_00_0 || got !== model_vec()) begin
            failures++;
            $display("FAIL simultaneous_still_play: got %b expected %b", got, 7'b01_00_00_0);
        end
    endtask

    task test_clear();
        do_reset();
        press(1, 0, 0); press(0, 1, 0); press(0, 1, 0); press(0, 1, 0);
        checks++;
        if (got !== 7'b01_11_10_1 || got !== model_vec()) begin
            failures++;
            $display("FAIL clear_setup_p2win: got %b expected %b", got, 7'b01_11_10_1);
        end
        press(0, 0, 1);
        checks++;
        if (got !== 7'b0 || got !== model_vec()) begin
            failures++;
            $display("FAIL clear_from_win: got %b expected %b", got, 7'b0);
        end
        press(0, 1, 0);
        checks++;
        if (got !== 7'b00_01_00_0 || got !== model_vec()) begin
            failures++;
            $display("FAIL clear_then_p2: got %b expected %b", got, 7'b00_01_00_0);
        end
        // Clear and a point rising together: clear wins.
        press(1, 0, 1);
        checks++;
        if (got !== 7'b0 || got !== model_vec()) begin
            failures++;
            $display("FAIL clear_priority: got %b expected %b", got, 7'b0);
        end
    endtask

    task test_random();
        int hold;
        do_reset();
        for (int seg = 0; seg < 600; seg++) begin
            btn_p1    = $urandom_range(0, 1);
            btn_p2    = $urandom_range(0, 1);
            btn_clear = ($urandom_range(0, 7) == 0);
            hold      = $urandom_range(1, 9);
            for (int c = 0; c < hold; c++) begin
                tick();
                checks++;
                if (got !== model_vec()) begin
                    failures++;
                    $display("FAIL random_seg%0d: got %b expected %b", seg, got, model_vec());
                end
            end
        end
        btn_p1 = 0; btn_p2 = 0; btn_clear = 0;
    endtask

    initial begin
        rst = 1'b1; btn_p1 = 0; btn_p2 = 0; btn_clear = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single_press();
        test_bounce();
        test_win();
        test_simultaneous();
        test_clear();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
